usb_rx_ctrl: RTL

- Sequencer between usb_rx and the shared packet data buffer; consumes the decoded packet category, the byte strobes and the end-of-packet pulse from usb_rx.
- Token packets: latches the category and reports it.
- DATA packets: forwards payload bytes to the buffer, strips the trailing CRC16, enforces the payload limit and raises completion/error status toward the AHB slave.

---
 rtl/usb_rx_pkg.sv | 25 ++
 rtl/usb_rx_crc_strip.sv | 47 ++++
 rtl/usb_rx_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types for the USB receive controller: packet categories, FSM states, defaults.
package usb_rx_pkg;

    typedef enum logic [2:0] {
        PKT_NONE  = 3'd0,
        PKT_OUT   = 3'd1,
        PKT_ACK   = 3'd2,
        PKT_IN    = 3'd3,
        PKT_NAK   = 3'd4,
        PKT_DATA0 = 3'd5,
        PKT_DATA1 = 3'd6,
        PKT_ERROR = 3'd7
    } rx_packet_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TOKEN,
        ST_DATA,
        ST_DISCARD
    } ctrl_state_t;

    localparam int DEF_MAX_PAYLOAD = 64;
    localparam int DEF_CNT_W       = 7;

endpackage

// File: rtl/usb_rx_crc_strip.sv
// Two-byte holding stage: delays payload by two bytes so the trailing CRC16 never reaches the buffer.
module usb_rx_crc_strip (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clear_i,
    input  logic       push_i,
    input  logic [7:0] data_i,
    output logic       full_o,
    output logic [1:0] cnt_o,
    output logic [7:0] head_o
);

    logic [7:0] h0_q, h0_d, h1_q, h1_d;
    logic [1:0] cnt_q, cnt_d;

    assign full_o = (cnt_q == 2'd2);
    assign cnt_o  = cnt_q;
    assign head_o = h0_q;

    always_comb begin
        h0_d  = h0_q;
        h1_d  = h1_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 2'd0;
        end else if (push_i) begin
            case (cnt_q)
                2'd0:    begin h0_d = data_i; cnt_d = 2'd1; end
                2'd1:    begin h1_d = data_i; cnt_d = 2'd2; end
                default: begin h0_d = h1_q;   h1_d  = data_i; end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            h0_q  <= '0;
            h1_q  <= '0;
            cnt_q <= '0;
        end else begin
            h0_q  <= h0_d;
            h1_q  <= h1_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/usb_rx_ctrl.sv
// Receive sequencer between usb_rx and the packet buffer: tokens, DATA payload, status.
// Optional data-toggle / duplicate detection: define USB_RX_TOGGLE_CHECK_EN.
module usb_rx_ctrl
    import usb_rx_pkg::*;
#(
    parameter int MAX_PAYLOAD = DEF_MAX_PAYLOAD,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [2:0]       rx_packet,
    input  logic             store_rx_packet,
    input  logic [7:0]       rx_packet_data,
    input  logic             rx_eop,
    input  logic             clear_status,
    output logic             buf_wr_en,
    output logic [7:0]       buf_wr_data,
    output logic             buf_flush,
    output logic [2:0]       rx_token,
    output logic             rx_token_valid,
    output logic             rx_transfer_active,
    output logic             rx_data_ready,
    output logic             rx_error,
    output logic [CNT_W-1:0] rx_byte_count,
    output logic             rx_dup
);

    rx_packet_t  pkt;
    ctrl_state_t state_q, state_d;
    rx_packet_t  pid_q, pid_d;
    logic [2:0]       tok_q, tok_d;
    logic             tok_vld_q, tok_vld_d;
    logic             wr_en_q, wr_en_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             flush_q, flush_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic             rdy_q, rdy_d, err_q, err_d;
    logic             rdy_set, err_set;
    logic             strip_clr, strip_push, strip_full;
    logic [1:0]       strip_cnt, held_after;
    logic [7:0]       strip_head;

    assign pkt = rx_packet_t'(rx_packet);

    usb_rx_crc_strip u_strip (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear_i (strip_clr),
        .push_i  (strip_push),
        .data_i  (rx_packet_data),
        .full_o  (strip_full),
        .cnt_o   (strip_cnt),
        .head_o  (strip_head)
    );

`ifdef USB_RX_TOGGLE_CHECK_EN
    logic tgl_q, tgl_d, dup_q, dup_d;
    assign rx_dup = dup_q;
`else
    assign rx_dup = 1'b0;
`endif

    // Held count as seen by EOP: a same-cycle strobe lands in the stage first.
    assign held_after = (strip_cnt == 2'd2 || !store_rx_packet) ? strip_cnt : strip_cnt + 2'd1;

    always_comb begin
        state_d    = state_q;
        pid_d      = pid_q;
        tok_d      = tok_q;
        tok_vld_d  = 1'b0;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        flush_d    = 1'b0;
        wcnt_d     = wcnt_q;
        rdy_set    = 1'b0;
        err_set    = 1'b0;
        strip_clr  = 1'b0;
        strip_push = 1'b0;
`ifdef USB_RX_TOGGLE_CHECK_EN
        tgl_d = tgl_q;
        dup_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                case (pkt)
                    PKT_OUT, PKT_IN, PKT_ACK, PKT_NAK: begin
                        state_d = ST_TOKEN;
                        pid_d   = pkt;
                    end
                    PKT_DATA0, PKT_DATA1: begin
                        if (rdy_q) begin
                            err_set = 1'b1;
                            state_d = ST_DISCARD;
                        end else begin
                            state_d   = ST_DATA;
                            pid_d     = pkt;
                            flush_d   = 1'b1;
                            strip_clr = 1'b1;
                            wcnt_d    = '0;
                        end
                    end
                    PKT_ERROR: begin
                        err_set = 1'b1;
                        state_d = ST_DISCARD;
                    end
                    default: ;
                endcase
            end
            ST_TOKEN: begin
                if (rx_eop) begin
                    tok_d     = pid_q;
                    tok_vld_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (pkt == PKT_ERROR) begin
                    err_set   = 1'b1;
                    flush_d   = 1'b1;
                    strip_clr = 1'b1;
                    state_d   = ST_DISCARD;
                end else begin
                    strip_push = store_rx_packet;
                    if (store_rx_packet && strip_full) begin
                        if (wcnt_q == CNT_W'(MAX_PAYLOAD)) begin
                            err_set   = 1'b1;
                            flush_d   = 1'b1;
                            strip_clr = 1'b1;
                            state_d   = ST_DISCARD;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_data_d = strip_head;
                            wcnt_d    = wcnt_q + CNT_W'(1);
                        end
                    end
                    if (rx_eop && state_d == ST_DATA) begin
                        state_d = ST_IDLE;
                        if (held_after == 2'd2) begin
`ifdef USB_RX_TOGGLE_CHECK_EN
                            if (pid_q == (tgl_q ? PKT_DATA1 : PKT_DATA0)) begin
                                rdy_set = 1'b1;
                                tgl_d   = ~tgl_q;
                            end else begin
                                dup_d     = 1'b1;
                                flush_d   = 1'b1;
                                strip_clr = 1'b1;
                            end
`else
                            rdy_set = 1'b1;
`endif
                        end else begin
                            err_set   = 1'b1;
                            flush_d   = 1'b1;
                            strip_clr = 1'b1;
                        end
                    end
                end
            end
            ST_DISCARD: begin
                if (rx_eop) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A status set always beats a coincident clear.
        rdy_d  = rdy_set | (rdy_q & ~clear_status);
        err_d  = err_set | (err_q & ~clear_status);
        bcnt_d = rdy_set ? wcnt_d : (clear_status ? '0 : bcnt_q);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= ST_IDLE;
            pid_q     <= PKT_NONE;
            tok_q     <= '0;
            tok_vld_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            flush_q   <= 1'b0;
            wcnt_q    <= '0;
            bcnt_q    <= '0;
            rdy_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pid_q     <= pid_d;
            tok_q     <= tok_d;
            tok_vld_q <= tok_vld_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            flush_q   <= flush_d;
            wcnt_q    <= wcnt_d;
            bcnt_q    <= bcnt_d;
            rdy_q     <= rdy_d;
            err_q     <= err_d;
        end
    end

`ifdef USB_RX_TOGGLE_CHECK_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tgl_q <= 1'b0;
            dup_q <= 1'b0;
        end else begin
            tgl_q <= tgl_d;
            dup_q <= dup_d;
        end
    end
`endif

    assign buf_wr_en          = wr_en_q;
    assign buf_wr_data        = wr_data_q;
    assign buf_flush          = flush_q;
    assign rx_token           = tok_q;
    assign rx_token_valid     = tok_vld_q;
    assign rx_transfer_active = (state_q == ST_DATA);
    assign rx_data_ready      = rdy_q;
    assign rx_error           = err_q;
    assign rx_byte_count      = bcnt_q;

endmodule
